// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with 2-bit direction counters, combinational lookup and
// resolved-branch update. Define BTP_GSHARE_EN to XOR the global history into the index.
module branch_target_predictor #(
  parameter int WIDTH_PC   = 32,
  parameter int INDEX_BITS = 7,
  parameter int TAG_BITS   = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  lookup_valid,
  input  logic [WIDTH_PC-1:0]   lookup_pc,
  output logic                  hit,
  output logic                  predict_taken,
  output logic [WIDTH_PC-1:0]   predict_pc,
  output logic [INDEX_BITS-1:0] lookup_ghr,
  input  logic                  upd_valid,
  input  logic [WIDTH_PC-1:0]   upd_pc,
  input  logic                  upd_taken,
  input  logic [WIDTH_PC-1:0]   upd_target,
  input  logic [INDEX_BITS-1:0] upd_ghr,
  input  logic                  flush
);
  localparam int DEPTH = 1 << INDEX_BITS;
  localparam int TGT_W = WIDTH_PC - 2;
  localparam int TAG_LO = INDEX_BITS + 2;
  localparam int TAG_HI = INDEX_BITS + TAG_BITS + 1;

  typedef struct packed {
    logic                valid;
    logic [TAG_BITS-1:0] tag;
    logic [TGT_W-1:0]    target;
    logic [1:0]          ctr;
  } entry_t;

  entry_t btb [DEPTH];

  logic [INDEX_BITS-1:0] lkIdx, updIdx;
  logic [TAG_BITS-1:0]   lkTag, updTag;
  entry_t                lkRd, updRd, updWr;
  logic                  updHit, updWe;

  assign lkTag  = lookup_pc[TAG_HI:TAG_LO];
  assign updTag = upd_pc[TAG_HI:TAG_LO];

`ifdef BTP_GSHARE_EN
  logic [INDEX_BITS-1:0] ghr;

  // History is rebuilt from the resolving branch's own snapshot, so a
  // mispredicted path never pollutes it.
  always_ff @(posedge clk) begin
    if (!rst_n)         ghr <= '0;
    else if (flush)     ghr <= '0;
    else if (upd_valid) ghr <= {upd_ghr[INDEX_BITS-2:0], upd_taken};
  end

  assign lookup_ghr = ghr;
  assign lkIdx      = lookup_pc[INDEX_BITS+1:2] ^ ghr;
  assign updIdx     = upd_pc[INDEX_BITS+1:2] ^ upd_ghr;
`else
  assign lookup_ghr = '0;
  assign lkIdx      = lookup_pc[INDEX_BITS+1:2];
  assign updIdx     = upd_pc[INDEX_BITS+1:2];
`endif

  logic unusedOk;
  assign unusedOk = ^{upd_pc[WIDTH_PC-1:TAG_HI+1], upd_pc[1:0], upd_target[1:0], upd_ghr};

  // Lookup: old table contents only, no bypass from a same-cycle update.
  always_comb begin
    lkRd          = btb[lkIdx];
    hit           = lookup_valid && lkRd.valid && (lkRd.tag == lkTag);
    predict_taken = hit && lkRd.ctr[1];
    predict_pc    = predict_taken ? {lkRd.target, 2'b00}
                                  : lookup_pc + WIDTH_PC'(4);
  end

  always_comb begin
    updRd  = btb[updIdx];
    updHit = updRd.valid && (updRd.tag == updTag);
    updWe  = 1'b0;
    updWr  = updRd;
    if (updHit) begin
      updWe = 1'b1;
      if (upd_taken) begin
        if (updRd.ctr != 2'b11) updWr.ctr = updRd.ctr + 2'd1;
        updWr.target = upd_target[WIDTH_PC-1:2];
      end else if (updRd.ctr != 2'b00) begin
        updWr.ctr = updRd.ctr - 2'd1;
      end
    end else if (upd_taken) begin
      // Allocate over whatever occupies the slot, starting weak-taken.
      updWe        = 1'b1;
      updWr.valid  = 1'b1;
      updWr.tag    = updTag;
      updWr.target = upd_target[WIDTH_PC-1:2];
      updWr.ctr    = 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        btb[i].valid  <= 1'b0;
        btb[i].tag    <= '0;
        btb[i].target <= '0;
        btb[i].ctr    <= 2'b01;
      end
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) btb[i].valid <= 1'b0;
    end else if (upd_valid && updWe) begin
      btb[updIdx] <= updWr;
    end
  end
endmodule

// File: doc/branch_target_predictor.md
# branch_target_predictor

Parametrised direct-mapped branch target buffer with per-entry 2-bit saturating direction counters, sitting in the PC stage beside the fetch address generator. A lookup returns hit, taken/not-taken and the predicted next PC combinationally for the current fetch PC. Resolved branches from execute update the table by actual outcome and target. The block also provides a one-cycle table flush and optional gshare-style global-history indexing.

## Interface
Parameters:
- `WIDTH_PC`, 32, PC width in bits.
- `INDEX_BITS`, 7, table index width; depth = 2^INDEX_BITS entries.
- `TAG_BITS`, 7, tag width; tag = pc[INDEX_BITS+TAG_BITS+1 : INDEX_BITS+2].

Ports:
- `clk` in 1: the only clock.
- `rst_n` in 1: reset, synchronous and active-low.
- `lookup_valid` in 1: current fetch instruction needs a prediction (B-type).
- `lookup_pc` in WIDTH_PC: PC being predicted.
- `hit` out 1: valid entry with matching tag, gated by `lookup_valid`.
- `predict_taken` out 1: hit & counter[1].
- `predict_pc` out WIDTH_PC: stored target when `predict_taken`, else `lookup_pc + 4`.
- `lookup_ghr` out INDEX_BITS: GHR snapshot; the pipeline carries it to execute.
- `upd_valid` in 1: a branch resolved this cycle.
- `upd_pc` in WIDTH_PC: PC of the resolved branch.
- `upd_taken` in 1: actual outcome.
- `upd_target` in WIDTH_PC: actual taken target; bits [1:0] are ignored.
- `upd_ghr` in INDEX_BITS: `lookup_ghr` value captured when this branch was predicted.
- `flush` in 1: invalidate all entries and clear the GHR.

## Operation
Entry fields:
- valid: 1 bit.
- tag: TAG_BITS.
- target: WIDTH_PC-2 bits, word-aligned.
- ctr: 2 bits; 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.

Lookup:
- Purely combinational.
- Index = lookup_pc[INDEX_BITS+1:2], XOR GHR when gshare is enabled.
- Tag compare on the tag field.

Update, applied on the clock edge sampling `upd_valid`=1:
- Index = upd_pc bits, XOR `upd_ghr` when gshare is enabled.
- Hit (valid and tag equal): ctr saturates +1 if taken, −1 if not taken. Target is rewritten only when taken.
- Miss and taken: allocate. valid=1, tag written, target=upd_target[WIDTH_PC-1:2], ctr=10. Any existing occupant is overwritten.
- Miss and not-taken: no table change.

GHR (INDEX_BITS wide):
- On `upd_valid`, GHR <= {upd_ghr[INDEX_BITS-2:0], upd_taken}.
- The GHR is non-speculative: it is rebuilt from the resolving branch's snapshot.

Reset:
- All valid=0, ctr=01, target=0, tag=0, GHR=0.
- Resulting outputs: `hit`=0, `predict_taken`=0, `predict_pc`=`lookup_pc`+4, `lookup_ghr`=0.

Flush:
- Clears every valid bit and the GHR in one cycle.
- ctr, tag and target are untouched.

Priority: reset > flush > update. An update in a flush cycle is dropped entirely, including its GHR update.

## Timing
- Lookup latency: 0 cycles (combinational from `lookup_pc` and the table state).
- Update is written at the edge sampling `upd_valid`. A lookup of the same index in that same cycle sees the old contents; there is no bypass. The new state is visible from the next cycle.
- Flush asserted in cycle N: all lookups in cycle N+1 miss.
- Reset asserted in the middle of operation takes effect at the next edge, with the same state as power-on reset.
- Only one update per cycle; `upd_valid` is a single-cycle strobe per branch.

## Configuration
`BTP_GSHARE_EN`:
- Defined: index = pc index bits XOR GHR, for both lookup and update (the update uses `upd_ghr`). The GHR shifts as described above.
- Undefined: index = pc index bits only. The GHR register is not built, `lookup_ghr` is tied to 0, and `upd_ghr` is ignored.

## Test plan
Default parameters, `BTP_GSHARE_EN` undefined unless stated. PC 0x100 maps to index 0x40, tag 0.
- Reset, then lookup 0x100 -> `hit`=0, `predict_taken`=0, `predict_pc`=0x104.
- Update 0x100 taken, target 0x80, then lookup 0x100 next cycle -> `hit`=1, `predict_taken`=1, `predict_pc`=0x80. The same-cycle lookup during the update still misses.
- Counter saturation on 0x100:
  - One not-taken update -> taken=0, `predict_pc`=0x104, `hit`=1.
  - Then three taken updates -> ctr=11.
  - Then one not-taken update -> ctr=10, taken=1.
- Not-taken update of 0x200 (miss) -> no allocation; lookup 0x200 gives `hit`=0.
- Aliasing and flush:
  - Taken update of 0x300 (index 0x40, tag 1), target 0x40 -> lookup 0x100 misses, lookup 0x300 hits with `predict_pc`=0x40.
  - `flush` together with `upd_valid` -> both miss next cycle and the update is lost.
- `BTP_GSHARE_EN` defined:
  - Three taken updates, each with `upd_ghr` equal to the current `lookup_ghr` -> `lookup_ghr`=0x07.
  - Update 0x100 taken with `upd_ghr`=0x07 allocates index 0x47; lookup 0x100 with GHR 0x07 hits.
  - After `flush`, `lookup_ghr`=0.
